dht11_data_receiver: RTL and testbench
======================================

Name: dht11_data_receiver

Overview:
- Downstream of the DHT11 start/handshake stage; armed by that stage's confirm output once the sensor response window has elapsed.
- Decodes the 40-bit DHT11 frame from the shared data line by measuring the high-pulse width of each bit.
- Validates the checksum and presents humidity/temperature bytes with a one-cycle valid strobe.
- Timing parameters are in clk cycles; defaults assume a 1 MHz clk (1 cycle = 1 us).

Parameters:
- BIT_THRESHOLD, 40: high-pulse length in cycles; count > BIT_THRESHOLD decodes '1', otherwise '0'.
- TIMEOUT_CYCLES, 200: maximum cycles allowed in any single waiting/measuring phase before abort.
- NUM_BITS, 40: bits per frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  level confirm from the start stage; a rising edge arms one frame capture.
- data_in  input  1  DHT11 data line, read-only here, asynchronous to clk.
- humidity_int  output  8  byte 0 of the last good frame.
- humidity_dec  output  8  byte 1.
- temp_int  output  8  byte 2.
- temp_dec  output  8  byte 3.
- data_valid  output  1  one-cycle pulse when a frame passes checksum.
- checksum_error  output  1  one-cycle pulse when a frame fails checksum.
- timeout_error  output  1  one-cycle pulse on phase timeout.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async):
  - All outputs 0.
  - State IDLE; shift register, bit counter and phase counter cleared.
  - Synchronizer and edge-detect flops preset to line idle (1).
  - start-edge flop cleared.
- Input conditioning:
  - data_in passes through a 2-FF synchronizer; the third stage is the previous sample.
  - fall = prev&~cur; rise = ~prev&cur.
  - start rising edge detected with a registered copy; a held-high start never retriggers.
- Phase counter: 8-bit, cleared on every state change, saturates at 255.
- States:
  - IDLE: on start rising edge -> WAIT_FALL.
  - WAIT_FALL: wait for fall (start of bit 0's ~50-cycle low) -> MEAS_LOW.
  - MEAS_LOW: on rise -> MEAS_HIGH.
  - MEAS_HIGH:
    - Count cycles while high.
    - On fall, shift bit (count > BIT_THRESHOLD) into the LSB of the 40-bit shift register (MSB-first frame) and increment bit counter.
    - If bit counter reaches NUM_BITS -> CHECK; else -> MEAS_LOW. The line is already low, so the fall begins the next bit.
  - CHECK:
    - If (b0+b1+b2+b3) mod 256 == b4: load the four output bytes and pulse data_valid.
    - Otherwise pulse checksum_error; output bytes hold previous values.
    - Either way -> IDLE next cycle.
- Timeout: in WAIT_FALL, MEAS_LOW or MEAS_HIGH, if the phase counter reaches TIMEOUT_CYCLES without the awaited edge -> pulse timeout_error, clear bit counter, -> IDLE. Output bytes are unchanged.
- Latency: data_valid/checksum_error is asserted in the cycle after the 40th bit's fall is detected, i.e. 3–4 clk after the physical falling edge including synchronization.
- Pulses: data_valid, checksum_error and timeout_error are mutually exclusive and each high exactly one cycle.
- Simultaneous events:
  - Edge and timeout in the same cycle: the edge wins.
  - start edge while busy: ignored.
- Reset mid-frame: immediate return to IDLE with all outputs 0. A partial frame is never reported.
- Rearm: a new capture requires start to go low and then high again.

Test Plan:
- Frame 0x37,0x00,0x19,0x00,0x50 with 50-cycle lows, 27-cycle '0' highs and 70-cycle '1' highs -> one data_valid pulse; humidity_int=55, humidity_dec=0, temp_int=25, temp_dec=0; busy falls the cycle after.
- Same frame with checksum 0x51 -> one checksum_error pulse, no data_valid, outputs retain prior values (55/0/25/0 after the first test).
- Threshold boundary: bit high for 40 cycles -> decodes 0; 41 cycles -> decodes 1. Verify via frame 0x80,0,0,0,0x80 and 0x00,...,0x00.
- Line stuck low after bit 10 -> timeout_error pulse exactly TIMEOUT_CYCLES=200 cycles into MEAS_LOW; state IDLE; no valid.
- rst pulsed low during bit 20 -> all outputs 0 asynchronously. A following full frame with a fresh start edge decodes correctly.
- start held high across two frame durations -> only one capture; a second frame is decoded only after start toggles 0->1.

Source files
------------

// File: rtl/dht11_data_receiver.sv
// DHT11 40-bit frame receiver: measures each bit's high-pulse width on the synchronized
// data line, checks the checksum and reports bytes with one-cycle status strobes.
module dht11_data_receiver #(
  parameter int BIT_THRESHOLD  = 40,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int NUM_BITS       = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       data_in,
  output logic [7:0] humidity_int,
  output logic [7:0] humidity_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       data_valid,
  output logic       checksum_error,
  output logic       timeout_error,
  output logic       busy
);

  localparam int            BW       = $clog2(NUM_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);
  localparam logic [7:0]    TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WAIT_FALL, MEAS_LOW, MEAS_HIGH, CHECK} state_e;

  state_e              state_q;
  logic                s1_q, cur_q, prev_q, start_q;
  logic [7:0]          cnt_q;
  logic [BW-1:0]       bitcnt_q;
  logic [NUM_BITS-1:0] sh_q;
  logic [7:0]          hum_int_q, hum_dec_q, tmp_int_q, tmp_dec_q;
  logic                valid_q, cksum_q, tmo_q;

  logic                fall, rise, start_rise, bit_val, timed_out;
  logic [8:0]          hi_len;
  logic [NUM_BITS-1:0] sh_d;
  logic [7:0]          sum_d;

  assign fall       = prev_q & ~cur_q;
  assign rise       = ~prev_q & cur_q;
  assign start_rise = start & ~start_q;
  assign timed_out  = (cnt_q >= TO_LAST);
  // cnt_q lags the physical high width by one cycle at the fall
  assign hi_len     = {1'b0, cnt_q} + 9'd1;
  assign bit_val    = (hi_len > 9'(BIT_THRESHOLD));
  assign sh_d       = {sh_q[NUM_BITS-2:0], bit_val};
  assign sum_d      = sh_d[NUM_BITS-1 -: 8] + sh_d[NUM_BITS-9 -: 8]
                    + sh_d[NUM_BITS-17 -: 8] + sh_d[NUM_BITS-25 -: 8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      s1_q      <= 1'b1;
      cur_q     <= 1'b1;
      prev_q    <= 1'b1;
      start_q   <= 1'b0;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      sh_q      <= '0;
      hum_int_q <= '0;
      hum_dec_q <= '0;
      tmp_int_q <= '0;
      tmp_dec_q <= '0;
      valid_q   <= 1'b0;
      cksum_q   <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      s1_q    <= data_in;
      cur_q   <= s1_q;
      prev_q  <= cur_q;
      start_q <= start;
      valid_q <= 1'b0;
      cksum_q <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      case (state_q)
        IDLE: if (start_rise) begin
          state_q  <= WAIT_FALL;
          cnt_q    <= '0;
          bitcnt_q <= '0;
        end
        WAIT_FALL, MEAS_LOW: begin
          if ((state_q == WAIT_FALL) ? fall : rise) begin
            state_q <= (state_q == WAIT_FALL) ? MEAS_LOW : MEAS_HIGH;
            cnt_q   <= '0;
          end else if (timed_out) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            tmo_q    <= 1'b1;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            sh_q  <= sh_d;
            cnt_q <= '0;
            if (bitcnt_q == LAST_BIT) begin
              // Report in the CHECK cycle so the strobe coincides with busy still high
              state_q  <= CHECK;
              bitcnt_q <= '0;
              if (sum_d == sh_d[7:0]) begin
                hum_int_q <= sh_d[NUM_BITS-1 -: 8];
                hum_dec_q <= sh_d[NUM_BITS-9 -: 8];
                tmp_int_q <= sh_d[NUM_BITS-17 -: 8];
                tmp_dec_q <= sh_d[NUM_BITS-25 -: 8];
                valid_q   <= 1'b1;
              end else begin
                cksum_q <= 1'b1;
              end
            end else begin
              state_q  <= MEAS_LOW;
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end else if (timed_out) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            tmo_q    <= 1'b1;
          end
        end
        CHECK: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign humidity_int   = hum_int_q;
  assign humidity_dec   = hum_dec_q;
  assign temp_int       = tmp_int_q;
  assign temp_dec       = tmp_dec_q;
  assign data_valid     = valid_q;
  assign checksum_error = cksum_q;
  assign timeout_error  = tmo_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_dht11_data_receiver.sv
// Scoreboard bench for dht11_data_receiver: stimulus pushes expected reports, a
// negedge monitor pops and compares whenever a status strobe appears.
module tb_dht11_data_receiver;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       data_in = 1'b1;
  logic [7:0] humidity_int, humidity_dec, temp_int, temp_dec;
  logic       data_valid, checksum_error, timeout_error, busy;

  dht11_data_receiver dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .humidity_int(humidity_int), .humidity_dec(humidity_dec),
    .temp_int(temp_int), .temp_dec(temp_dec),
    .data_valid(data_valid), .checksum_error(checksum_error),
    .timeout_error(timeout_error), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] K_VALID = 2'd0, K_CKSUM = 2'd1, K_TMO = 2'd2;
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] bytes;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expected report
  always @(negedge clk) begin
    if (rst && (data_valid || checksum_error || timeout_error)) begin
      logic [1:0] k;
      exp_t       e;
      k = data_valid ? K_VALID : (checksum_error ? K_CKSUM : K_TMO);
      chk("pulse_exclusive", 64'(data_valid + checksum_error + timeout_error), 64'd1);
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got kind %0d expected none", k);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", 64'(k), 64'(e.kind));
        chk("out_bytes", 64'({humidity_int, humidity_dec, temp_int, temp_dec}), 64'(e.bytes));
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int hi0, input int hi1);
    data_in = 1'b0;
    hold(50);
    data_in = 1'b1;
    hold(b ? hi1 : hi0);
  endtask

  task automatic send_bits(input logic [39:0] f, input int n, input int hi0, input int hi1);
    data_in = 1'b1;
    hold(10);
    for (int i = 0; i < n; i++) send_bit(f[39-i], hi0, hi1);
  endtask

  task automatic send_frame(input logic [39:0] f, input int hi0, input int hi1);
    send_bits(f, 40, hi0, hi1);
    data_in = 1'b0;
    hold(50);
    data_in = 1'b1;
    hold(20);
  endtask

  task automatic arm();
    start = 1'b0;
    hold(3);
    start = 1'b1;
    hold(2);
  endtask

  task automatic expect_rep(input logic [1:0] k, input logic [31:0] b);
    exp_t e;
    e.kind  = k;
    e.bytes = b;
    q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    chk(name, 64'(q.size()), 64'd0);
  endtask

  localparam logic [39:0] FR_A   = 40'h37_00_19_00_50;
  localparam logic [39:0] FR_BAD = 40'h37_00_19_00_51;
  localparam logic [39:0] FR_TH  = 40'h80_00_00_00_80;
  localparam logic [39:0] FR_B   = 40'h40_05_1A_03_62;

  initial begin
    int n;
    #1;
    chk("reset_outputs", 64'({humidity_int, humidity_dec, temp_int, temp_dec,
        data_valid, checksum_error, timeout_error, busy}), 64'd0);
    hold(3);
    rst = 1'b1;
    hold(3);
    chk("idle_busy", 64'(busy), 64'd0);

    // Good frame
    arm();
    chk("armed_busy", 64'(busy), 64'd1);
    expect_rep(K_VALID, 32'h37_00_19_00);
    send_frame(FR_A, 27, 70);
    wait_drain("frame_a_report");
    chk("frame_a_busy_low", 64'(busy), 64'd0);

    // Bad checksum retains previous bytes
    arm();
    expect_rep(K_CKSUM, 32'h37_00_19_00);
    send_frame(FR_BAD, 27, 70);
    wait_drain("bad_cksum_report");

    // Threshold: 41-cycle highs decode 1, 40-cycle highs decode 0
    arm();
    expect_rep(K_VALID, 32'h80_00_00_00);
    send_frame(FR_TH, 40, 41);
    wait_drain("thr_41_report");
    arm();
    expect_rep(K_VALID, 32'h00_00_00_00);
    send_frame(FR_TH, 40, 40);
    wait_drain("thr_40_report");

    // Line stuck low after bit 10
    arm();
    expect_rep(K_TMO, 32'h00_00_00_00);
    send_bits(FR_A, 11, 27, 70);
    data_in = 1'b0;
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (timeout_error) begin
        n = i;
        break;
      end
    end
    chk("timeout_latency_window", 64'((n >= 200) && (n <= 206)), 64'd1);
    hold(1);
    chk("timeout_idle", 64'(busy), 64'd0);
    wait_drain("timeout_report");
    data_in = 1'b1;
    hold(10);

    // Reload bytes, then reset mid bit 20
    arm();
    expect_rep(K_VALID, 32'h37_00_19_00);
    send_frame(FR_A, 27, 70);
    wait_drain("frame_a2_report");
    arm();
    send_bits(FR_B, 20, 27, 70);
    data_in = 1'b0;
    hold(50);
    data_in = 1'b1;
    hold(10);
    #2 rst = 1'b0;
    #1;
    chk("midframe_reset_outputs", 64'({humidity_int, humidity_dec, temp_int, temp_dec,
        data_valid, checksum_error, timeout_error, busy}), 64'd0);
    start = 1'b0;
    hold(3);
    rst = 1'b1;
    hold(5);
    arm();
    expect_rep(K_VALID, 32'h37_00_19_00);
    send_frame(FR_A, 27, 70);
    wait_drain("post_reset_report");

    // Held-high start captures once only
    arm();
    expect_rep(K_VALID, 32'h37_00_19_00);
    send_frame(FR_A, 27, 70);
    wait_drain("held_first_report");
    send_frame(FR_B, 27, 70);
    hold(20);
    chk("held_no_rearm_busy", 64'(busy), 64'd0);
    chk("held_no_rearm_bytes", 64'({humidity_int, humidity_dec, temp_int, temp_dec}),
        64'h37_00_19_00);
    arm();
    expect_rep(K_VALID, 32'h40_05_1A_03);
    send_frame(FR_B, 27, 70);
    wait_drain("rearm_report");

    hold(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
